pc_write_unit: RTL
==================

Name: pc_write_unit

Overview:
- Program-counter stage directly downstream of the PC-source multiplexer in the multicycle MIPS datapath.
- Registers the selected next-PC and decides when a write commits: unconditional write, or conditional branch evaluated from ALU flags.
- Detects misaligned PC targets, captures EPC on exceptions, and holds an exception-pending state until the control unit loads the handler vector.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- EPC_OFFSET, 32'd4, subtracted from the current PC when EPC is captured (PC is already incremented past the faulting instruction).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-low reset.
- pc_next  input  32  candidate next PC from the PC-source mux output.
- pc_write  input  1  unconditional PC write request.
- pc_write_cond  input  1  conditional (branch) PC write request.
- branch_op  input  2  00 beq, 01 bne, 10 ble, 11 bgt.
- alu_zero  input  1  ALU zero flag.
- alu_gt  input  1  ALU greater-than flag (A > B, signed).
- exc_req  input  1  external exception (overflow, invalid opcode, ...) from control.
- exc_ack  input  1  control acknowledges the exception; next pc_write loads the handler vector.
- pc_out  output  32  current PC.
- epc_out  output  32  exception PC.
- misalign_exc  output  1  level: misaligned-target exception pending.
- exc_pending  output  1  level: FSM in EXC state.
- pc_written  output  1  one-cycle pulse: PC updated this edge.

Behaviour:
- Clock/reset: one clock, clk; reset is synchronous and active-low. With reset low at a rising edge: pc_out = RESET_PC, epc_out = 0, misalign_exc = 0, exc_pending = 0, pc_written = 0, FSM = RUN, regardless of any other input. Reset asserted mid-exception clears everything.
- Branch condition, combinational: take = beq: alu_zero; bne: !alu_zero; ble: !alu_gt; bgt: alu_gt.
- Write request: req = pc_write | (pc_write_cond & take). pc_write has priority; a cond write with take = 0 is a no-op.
- All register updates occur on the rising edge; pc_out reflects the new value one cycle after the request.
- FSM RUN:
  - exc_req = 1: EPC <= pc_out - EPC_OFFSET; PC unchanged; go to EXC; exc_pending = 1. This overrides a simultaneous req.
  - Otherwise, req with pc_next[1:0] != 2'b00: PC unchanged; EPC <= pc_out - EPC_OFFSET; misalign_exc = 1; go to EXC.
  - Otherwise, req: PC <= pc_next; pc_written pulses for one cycle.
- FSM EXC:
  - exc_req ignored (no nested capture); EPC held.
  - Before exc_ack, req is ignored and PC is held.
  - exc_ack sets an internal ack flag, which stays set until consumed.
  - With the ack flag set (or exc_ack in the same cycle), the next pc_write loads pc_next without the alignment check. pc_written pulses; misalign_exc, exc_pending and the ack flag clear; go to RUN.
  - pc_write_cond is ignored in EXC.
- Arithmetic: EPC subtraction is 32-bit modulo; PC = 0 gives EPC = 32'hFFFF_FFFC.
- pc_written is 0 in every cycle in which PC did not change due to a write.

Optional Feature:
- Macro PC_BRANCH_COUNT_EN.
- When defined: adds output branch_taken_cnt [15:0]. It increments on each committed write caused by pc_write_cond & take with pc_write = 0, in RUN, aligned target. It saturates at 16'hFFFF and resets to 0.
- When undefined: the port and counter do not exist; all other behaviour is identical.

Test Plan:
- Reset low for 2 cycles, then high -> pc_out = 0, epc_out = 0, all flags 0. Then pc_write with pc_next = 0x4 -> pc_out = 0x4 next cycle, pc_written pulse.
- pc_out = 0x100, pc_write_cond, branch_op = 00, alu_zero = 0 -> PC stays 0x100, no pulse. Repeat with alu_zero = 1, pc_next = 0x140 -> PC = 0x140. bgt with alu_gt = 1 -> taken; ble with alu_gt = 1 -> not taken.
- pc_out = 0x200, pc_write, pc_next = 0x202 -> PC stays 0x200, epc_out = 0x1FC, misalign_exc = 1, exc_pending = 1. Further pc_write ignored until exc_ack. Then pc_write with pc_next = 0x8000_0000 -> PC = 0x8000_0000, flags clear.
- pc_out = 0x300, exc_req and pc_write together (pc_next = 0x304) -> PC stays 0x300, epc_out = 0x2FC, misalign_exc = 0. A second exc_req while in EXC -> epc_out unchanged.
- In EXC, assert reset low for one edge -> pc_out = 0, flags 0, FSM RUN. An aligned write then commits normally.
- With PC_BRANCH_COUNT_EN defined: 3 taken branches, 2 not-taken, 1 pc_write -> branch_taken_cnt = 3. Preload the counter near 0xFFFF via repeated taken branches -> holds at 0xFFFF.

Source files
------------

// File: rtl/pc_write_unit.sv
// pc_write_unit -- program-counter register stage behind the PC-source mux
// of a multicycle MIPS datapath.
//
// Commits the candidate next-PC on an unconditional write or a taken branch.
// A misaligned target or an external exception request raises a pending
// exception: the faulting return address is captured into EPC, and the PC is
// frozen until the control unit acknowledges the exception and loads the
// handler vector with pc_write.
//
// Optional build feature (macro PC_BRANCH_COUNT_EN): adds a saturating 16-bit
// counter of committed branch-only writes on output branch_taken_cnt.
module pc_write_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter logic [31:0] EPC_OFFSET = 32'd4
) (
  input  logic        clk,
  input  logic        reset,          // synchronous, active-low
  input  logic [31:0] pc_next,
  input  logic        pc_write,
  input  logic        pc_write_cond,
  input  logic [1:0]  branch_op,
  input  logic        alu_zero,
  input  logic        alu_gt,
  input  logic        exc_req,
  input  logic        exc_ack,
  output logic [31:0] pc_out,
  output logic [31:0] epc_out,
  output logic        misalign_exc,
  output logic        exc_pending,
`ifdef PC_BRANCH_COUNT_EN
  output logic [15:0] branch_taken_cnt,
`endif
  output logic        pc_written
);

  typedef enum logic [1:0] {
    BR_EQ = 2'b00,
    BR_NE = 2'b01,
    BR_LE = 2'b10,
    BR_GT = 2'b11
  } branch_op_e;

  typedef enum logic {
    ST_RUN = 1'b0,
    ST_EXC = 1'b1
  } state_e;

  state_e      state_q;
  logic [31:0] pc_q;
  logic [31:0] epc_q;
  logic        misalign_q;
  logic        written_q;
  logic        ack_q;
`ifdef PC_BRANCH_COUNT_EN
  logic [15:0] br_cnt_q;
`endif

  logic        take;
  logic        req;
  logic        cond_only;
  logic        misaligned;
  logic [31:0] epc_d;

  // Branch outcome decoded from the ALU flags.
  // NOTE: every output of a combinational block gets a default first, so no
  // path through the case leaves it unassigned and no latch is inferred.
  always_comb begin
    take = 1'b0;
    unique case (branch_op_e'(branch_op))
      BR_EQ: take = alu_zero;
      BR_NE: take = ~alu_zero;
      BR_LE: take = ~alu_gt;
      BR_GT: take = alu_gt;
      default: take = 1'b0;
    endcase
  end

  assign req        = pc_write | (pc_write_cond & take);
  assign cond_only  = ~pc_write & pc_write_cond & take;
  assign misaligned = (pc_next[1:0] != 2'b00);
  // PC has already advanced past the faulting instruction; wraps modulo 2^32.
  assign epc_d      = pc_q - EPC_OFFSET;

  // Exception FSM with registered PC, EPC, flags and the write pulse.
  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values and evaluation order cannot matter.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= ST_RUN;
      pc_q       <= RESET_PC;
      epc_q      <= '0;
      misalign_q <= 1'b0;
      written_q  <= 1'b0;
      ack_q      <= 1'b0;
`ifdef PC_BRANCH_COUNT_EN
      br_cnt_q   <= '0;
`endif
    end else begin
      written_q <= 1'b0;
      unique case (state_q)
        ST_RUN: begin
          if (exc_req) begin
            // External exception wins over any write request this cycle.
            epc_q   <= epc_d;
            state_q <= ST_EXC;
          end else if (req && misaligned) begin
            epc_q      <= epc_d;
            misalign_q <= 1'b1;
            state_q    <= ST_EXC;
          end else if (req) begin
            pc_q      <= pc_next;
            written_q <= 1'b1;
`ifdef PC_BRANCH_COUNT_EN
            if (cond_only && br_cnt_q != 16'hFFFF) begin
              br_cnt_q <= br_cnt_q + 16'd1;
            end
`endif
          end
        end
        ST_EXC: begin
          // Handler vector load: no alignment check, branches ignored.
          if (pc_write && (ack_q || exc_ack)) begin
            pc_q       <= pc_next;
            written_q  <= 1'b1;
            misalign_q <= 1'b0;
            ack_q      <= 1'b0;
            state_q    <= ST_RUN;
          end else if (exc_ack) begin
            ack_q <= 1'b1;
          end
        end
        default: state_q <= ST_RUN;
      endcase
    end
  end

`ifndef PC_BRANCH_COUNT_EN
  // Branch-only commits matter only to the optional counter.
  logic unused_cond_only;
  assign unused_cond_only = cond_only;
`endif

  assign pc_out       = pc_q;
  assign epc_out      = epc_q;
  assign misalign_exc = misalign_q;
  assign exc_pending  = (state_q == ST_EXC);
  assign pc_written   = written_q;
`ifdef PC_BRANCH_COUNT_EN
  assign branch_taken_cnt = br_cnt_q;
`endif

endmodule
